// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with programmable slot
// length, start-of-slot anti-ghosting blanking, per-digit enables and registered pin drive.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_W          = 7,
  parameter int DIV_W          = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_W-1:0]            tick_div,
  input  logic [DIV_W-1:0]            blank_cycles,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        dp_out,
  output logic [NUM_DIGITS-1:0]       sel_out,
  output logic                        frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      SEG_IDLE = {SEG_W{SEG_ACTIVE_LOW}};

  logic [IDX_W-1:0]      idx;
  logic [DIV_W-1:0]      cnt;
  logic [DIV_W-1:0]      tick_q;
  logic [DIV_W-1:0]      blank_q;

  logic                  visible;
  logic                  slot_end;
  logic                  frame_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [SEG_W-1:0]      seg_nxt;
  logic                  dp_nxt;

  // Active-high pin image of the current (idx, cnt) state; polarity is applied at the register.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sel_nxt = '0;
    seg_nxt = '0;
    dp_nxt  = 1'b0;
    visible = (cnt >= blank_q) && digit_en[idx];
    if (visible) begin
      sel_nxt[idx] = 1'b1;
      seg_nxt      = seg_in[idx*SEG_W +: SEG_W];
      dp_nxt       = dp_in[idx];
    end
  end

  assign slot_end  = (cnt == tick_q);
  assign frame_nxt = (idx == '0) && (cnt == '0);

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; all state uses non-blocking assignments.
    if (!rst_n) begin
      idx         <= '0;
      cnt         <= '0;
      tick_q      <= tick_div;
      blank_q     <= blank_cycles;
      sel_out     <= SEL_IDLE;
      seg_out     <= SEG_IDLE;
      dp_out      <= SEG_ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      // Slot timing is latched only at the boundary so a slot always completes as started.
      if (slot_end) begin
        cnt     <= '0;
        idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        tick_q  <= tick_div;
        blank_q <= blank_cycles;
      end else begin
        cnt <= cnt + 1'b1;
      end
      sel_out     <= sel_nxt ^ SEL_IDLE;
      seg_out     <= seg_nxt ^ SEG_IDLE;
      dp_out      <= dp_nxt ^ SEG_ACTIVE_LOW;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a 4-digit active-high and a 6-digit active-low instance
// run side by side against a slot-schedule reference model under random segment data.
module tb_seg_scan_ctrl;

  localparam int NA = 4;
  localparam int NB = 6;
  localparam int SW = 7;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]    tick_a, blank_a, tick_b, blank_b;
  logic [NA-1:0]    en_a, dp_a_in, sel_a;
  logic [NA*SW-1:0] seg_a_in;
  logic [SW-1:0]    seg_a;
  logic             dp_a, fr_a;
  logic [NB-1:0]    en_b, dp_b_in, sel_b;
  logic [NB*SW-1:0] seg_b_in;
  logic [SW-1:0]    seg_b;
  logic             dp_b, fr_b;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.NUM_DIGITS(NA), .SEG_W(SW), .DIV_W(DW),
                  .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_div(tick_a), .blank_cycles(blank_a),
    .digit_en(en_a), .seg_in(seg_a_in), .dp_in(dp_a_in),
    .seg_out(seg_a), .dp_out(dp_a), .sel_out(sel_a), .frame_start(fr_a));

  seg_scan_ctrl #(.NUM_DIGITS(NB), .SEG_W(SW), .DIV_W(DW),
                  .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_div(tick_b), .blank_cycles(blank_b),
    .digit_en(en_b), .seg_in(seg_b_in), .dp_in(dp_b_in),
    .seg_out(seg_b), .dp_out(dp_b), .sel_out(sel_b), .frame_start(fr_b));

  // Reference model: a slot is (digit, position within slot, length, blanked prefix).
  typedef struct {
    int digit;
    int pos;
    int len;
    int blank;
  } slot_t;

  slot_t ma, mb;

  // Expected {frame, sel[5:0], dp, seg[6:0]} for one output cycle.
  function automatic logic [14:0] model_out(slot_t s, logic [5:0] en, logic [41:0] seg,
                                            logic [5:0] dp, bit low);
    logic [5:0] sel = '0;
    logic [6:0] sg  = '0;
    logic       d   = 1'b0;
    logic       fr;
    fr = (s.digit == 0) && (s.pos == 0);
    if (s.pos >= s.blank && en[s.digit]) begin
      sel[s.digit] = 1'b1;
      sg = seg[s.digit*7 +: 7];
      d  = dp[s.digit];
    end
    if (low) begin
      sel = ~sel;
      sg  = ~sg;
      d   = ~d;
    end
    return {fr, sel, d, sg};
  endfunction

  function automatic logic [14:0] reset_out(bit low);
    return low ? {1'b0, 6'h3F, 1'b1, 7'h7F} : 15'h0;
  endfunction

  function automatic slot_t fresh(logic [DW-1:0] tick, logic [DW-1:0] blank);
    slot_t s;
    s.digit = 0;
    s.pos   = 0;
    s.len   = int'(tick) + 1;
    s.blank = int'(blank);
    return s;
  endfunction

  function automatic slot_t advance(slot_t s, int n, logic [DW-1:0] tick, logic [DW-1:0] blank);
    slot_t r = s;
    if (s.pos == s.len - 1) begin
      r       = fresh(tick, blank);
      r.digit = (s.digit + 1) % n;
    end else begin
      r.pos = s.pos + 1;
    end
    return r;
  endfunction

  task automatic set_cfg(int tick, int blank, logic [3:0] ea, logic [5:0] eb);
    tick_a  = DW'(tick);
    tick_b  = DW'(tick);
    blank_a = DW'(blank);
    blank_b = DW'(blank);
    en_a    = ea;
    en_b    = eb;
  endtask

  // One clock: fresh random data, predict, clock, compare both instances.
  task automatic cycle();
    logic [63:0] r1, r2;
    logic [14:0] ea, eb, oa, ob;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    seg_a_in = r1[NA*SW-1:0];
    dp_a_in  = r1[63:60];
    seg_b_in = r2[NB*SW-1:0];
    dp_b_in  = r2[63:58];
    ea = rst_n ? model_out(ma, {2'b00, en_a}, {14'h0, seg_a_in}, {2'b00, dp_a_in}, 1'b0)
               : reset_out(1'b0);
    eb = rst_n ? model_out(mb, en_b, seg_b_in, dp_b_in, 1'b1) : reset_out(1'b1);
    ma = rst_n ? advance(ma, NA, tick_a, blank_a) : fresh(tick_a, blank_a);
    mb = rst_n ? advance(mb, NB, tick_b, blank_b) : fresh(tick_b, blank_b);
    @(posedge clk);
    @(negedge clk);
    oa = {fr_a, 2'b00, sel_a, dp_a, seg_a};
    ob = {fr_b, sel_b, dp_b, seg_b};
    n_checks++;
    if (oa !== ea) begin
      n_fail++;
      $display("FAIL dut_a_outputs t=%0t got=%h expected=%h", $time, oa, ea);
    end
    n_checks++;
    if (ob !== eb) begin
      n_fail++;
      $display("FAIL dut_b_outputs t=%0t got=%h expected=%h", $time, ob, eb);
    end
    n_checks++;
    if ($countones(sel_a) > 1 || $countones(~sel_b) > 1) begin
      n_fail++;
      $display("FAIL sel_one_hot t=%0t got sel_a=%b sel_b=%b expected at most one active", $time, sel_a, sel_b);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_cfg(0, 0, 4'hF, 6'h3F);
    rst_n = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (sel_a !== 4'h0 || fr_a !== 1'b0 || sel_b !== 6'h3F || seg_b !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_idle got sel_a=%b fr_a=%b sel_b=%b seg_b=%b expected 0000 0 111111 1111111",
               sel_a, fr_a, sel_b, seg_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fast_scan();
    logic [3:0] exp_sel;
    set_cfg(0, 0, 4'hF, 6'h3F);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle();
      exp_sel = 4'b0001 << (k % 4);
      n_checks++;
      if (sel_a !== exp_sel || fr_a !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL fast_scan k=%0d got sel=%b fr=%b expected sel=%b fr=%b",
                 k, sel_a, fr_a, exp_sel, (k % 4 == 0));
      end
    end
  endtask

  task automatic test_blank_dp();
    int lit = 0, frames = 0;
    set_cfg(3, 1, 4'hF, 6'h3F);
    do_reset();
    for (int k = 0; k < 32; k++) begin
      cycle();
      if (sel_a != 4'h0) lit++;
      if (fr_a) frames++;
    end
    n_checks++;
    if (lit != 24 || frames != 2) begin
      n_fail++;
      $display("FAIL blank_dp got lit=%0d frames=%0d expected lit=24 frames=2", lit, frames);
    end
  endtask

  task automatic test_digit_en();
    int slot2 = 0, dark = 0, frames = 0;
    set_cfg(3, 0, 4'b1011, 6'b111011);
    do_reset();
    for (int k = 0; k < 32; k++) begin
      cycle();
      if (sel_a == 4'b0100) slot2++;
      if (sel_a == 4'h0 && seg_a == 7'h0 && dp_a == 1'b0) dark++;
      if (fr_a) frames++;
    end
    n_checks++;
    if (slot2 != 0 || dark != 8 || frames != 2) begin
      n_fail++;
      $display("FAIL digit_en got slot2=%0d dark=%0d frames=%0d expected 0 8 2", slot2, dark, frames);
    end
  endtask

  task automatic test_tick_change();
    int s1 = 0, s2 = 0;
    set_cfg(3, 0, 4'hF, 6'h3F);
    do_reset();
    for (int k = 0; k < 25; k++) begin
      if (k == 5) begin
        tick_a = 16'd7;
        tick_b = 16'd7;
      end
      cycle();
      if (sel_a == 4'b0010) s1++;
      if (sel_a == 4'b0100) s2++;
    end
    n_checks++;
    if (s1 != 4 || s2 != 8) begin
      n_fail++;
      $display("FAIL tick_change got slot1=%0d slot2=%0d expected 4 8", s1, s2);
    end
  endtask

  task automatic test_all_blank();
    int lit = 0, frames = 0;
    set_cfg(3, 5, 4'hF, 6'h3F);
    do_reset();
    for (int k = 0; k < 32; k++) begin
      cycle();
      if (sel_a != 4'h0 || seg_a != 7'h0 || sel_b != 6'h3F) lit++;
      if (fr_a) frames++;
    end
    n_checks++;
    if (lit != 0 || frames != 2) begin
      n_fail++;
      $display("FAIL all_blank got lit=%0d frames=%0d expected 0 2", lit, frames);
    end
  endtask

  task automatic test_reset_mid_slot();
    set_cfg(2, 0, 4'hF, 6'h3F);
    do_reset();
    for (int k = 0; k < 7; k++) cycle();
    rst_n = 1'b0;
    cycle();
    n_checks++;
    if (sel_b !== 6'h3F || seg_b !== 7'h7F || dp_b !== 1'b1 || fr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_slot_idle got sel=%b seg=%b dp=%b fr=%b expected 111111 1111111 1 0",
               sel_b, seg_b, dp_b, fr_b);
    end
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (fr_b !== 1'b1 || sel_b !== 6'b111110 || seg_b !== ~seg_b_in[6:0]) begin
      n_fail++;
      $display("FAIL reset_mid_slot_release got fr=%b sel=%b seg=%b expected 1 111110 %b",
               fr_b, sel_b, seg_b, ~seg_b_in[6:0]);
    end
    for (int k = 0; k < 6; k++) cycle();
  endtask

  task automatic test_random();
    set_cfg(2, 1, 4'hF, 6'h3F);
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(9) == 0) begin
        tick_a  = DW'($urandom_range(5));
        blank_a = DW'($urandom_range(6));
        tick_b  = DW'($urandom_range(5));
        blank_b = DW'($urandom_range(6));
        en_a    = NA'($urandom);
        en_b    = NB'($urandom);
      end
      rst_n = ($urandom_range(49) != 0);
      cycle();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    set_cfg(0, 0, 4'hF, 6'h3F);
    seg_a_in = '0;
    dp_a_in  = '0;
    seg_b_in = '0;
    dp_b_in  = '0;
    ma = fresh(tick_a, blank_a);
    mb = fresh(tick_b, blank_b);
    @(negedge clk);
    test_reset();
    test_fast_scan();
    test_blank_dp();
    test_digit_en();
    test_tick_change();
    test_all_blank();
    test_reset_mid_slot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
